ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//  Read-side master for dual_ram_module (port B). A start command with a base address and
//  a length makes the block issue sequential 1-cycle-latency reads (i_enb/i_raddr). The
//  returned words are presented as a valid/ready stream with full backpressure, through an
//  internal 2-entry buffer. It is the consumer end of the RAM that a writer fills via port A.
// PARAMETERS
//  P_DATA_WIDTH  4    word width; must equal the RAM's P_DATA_WIDTH
//  P_ADDR_DEPTH  128  RAM depth; AW = clogb2(P_ADDR_DEPTH-1), same function as the RAM
// PORTS
//  i_clk        in   1     clock
//  i_rst        in   1     reset, asynchronous, active-high
//  i_start      in   1     start pulse; sampled only in IDLE
//  i_base_addr  in   AW    first read address
//  i_len        in   AW+1  words to read; 0 = empty job; values >P_ADDR_DEPTH clamp to P_ADDR_DEPTH
//  o_busy       out  1     high from the cycle after start is accepted until o_done
//  o_done       out  1     1-cycle pulse at job end
//  o_ram_en     out  1     to RAM i_enb
//  o_ram_addr   out  AW    to RAM i_raddr
//  i_ram_rdata  in   DW    from RAM o_rdata; valid the cycle after o_ram_en
//  o_valid      out  1     stream word valid
//  o_data       out  DW    stream word
//  o_last       out  1     qualifies the final word of the job (valid only with o_valid)
//  i_ready      in   1     downstream accept; transfer = o_valid & i_ready
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; buffer, counters and the in-flight flag are cleared.
//  FSM IDLE -> READ on i_start; it latches base, clamped len and remaining counters.
//   IDLE -> DONE when i_start and len==0; no reads, no beats.
//   READ -> DONE once every word has been issued, the buffer is empty, nothing is in
//   flight, and the last beat has transferred.
//   DONE: o_done=1 for one cycle, o_busy=0; -> IDLE. i_start in READ/DONE is ignored.
//  Issue rule: o_ram_en=1 in READ when issue_left>0 and (buf_cnt + inflight - pop) < 2,
//   where pop = o_valid & i_ready. o_ram_addr is registered together with o_ram_en.
//  Address: starts at base and increments after each issue; wraps from P_ADDR_DEPTH-1 to 0
//   with an explicit compare, so a non-power-of-2 depth also wraps correctly.
//  inflight is set the cycle after o_ram_en. In that cycle i_ram_rdata is written into the
//   2-entry buffer, together with a last tag (1 on the final issued word).
//  Buffer: 2-entry FIFO with a registered head. o_valid = (buf_cnt != 0); o_data/o_last come
//   from the head. Push and pop in the same cycle are legal and leave the count unchanged.
//   Overflow cannot occur under the issue rule; an overflow is a bench assertion failure.
//  Stream rule: while o_valid=1 and i_ready=0, o_data and o_last hold stable. o_valid never
//   drops until its transfer.
//  Latency: start sampled at cycle T -> o_ram_en at T+1 (addr=base) -> o_valid at T+3.
//   With i_ready held at 1 the block sustains one word per cycle.
//  o_done asserts the cycle after the last transfer. A new start is accepted in the
//   following IDLE cycle.
//  Reset mid-job: abort immediately, drop buffered data, no o_done.
// TESTING
//  1 DW=4, DEPTH=128, RAM[i]=i[3:0]; start base=5, len=4, i_ready=1 -> o_valid at T+3 with
//    data 5,6,7,8 on consecutive cycles; o_last on 8; o_done one cycle later.
//  2 base=126, len=4 -> o_ram_addr 126,127,0,1; data matches; o_last on 4th beat.
//  3 len=6, i_ready toggles 1,0,0,1,... -> no loss or duplication; data stable while
//    stalled; o_ram_en count==6; buffer count never exceeds 2.
//  4 len=0 -> o_done pulse at T+1, o_ram_en never set, o_valid never set.
//  5 len=200 -> clamped to 128 beats, address wraps to base; i_start mid-job is ignored.
//  6 i_rst pulsed after the 2nd beat of len=8 -> all outputs 0 async, no o_done; a new job
//    runs cleanly after reset.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a block of words from a 1-cycle-latency RAM and streams them out with valid/ready backpressure.
//  i_clk, i_rst        clock; asynchronous active-high reset
//  i_start             start pulse, only sampled while idle
//  i_base_addr, i_len  first address and word count (0 = empty job, clamped to the RAM depth)
//  o_busy, o_done      job running; one-cycle pulse at job end
//  o_ram_en, o_ram_addr, i_ram_rdata   RAM read port (data returns the cycle after o_ram_en)
//  o_valid, o_data, o_last, i_ready    output stream; o_last marks the final word of the job
module ram_stream_reader #(
    parameter int P_DATA_WIDTH = 4,
    parameter int P_ADDR_DEPTH = 128,
    localparam int AW = (P_ADDR_DEPTH > 1) ? $clog2(P_ADDR_DEPTH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [AW-1:0]           i_base_addr,
    input  logic [AW:0]             i_len,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_ram_en,
    output logic [AW-1:0]           o_ram_addr,
    input  logic [P_DATA_WIDTH-1:0] i_ram_rdata,
    output logic                    o_valid,
    output logic [P_DATA_WIDTH-1:0] o_data,
    output logic                    o_last,
    input  logic                    i_ready
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;
    localparam logic [AW:0]   LEN_MAX   = (AW+1)'(P_ADDR_DEPTH);
    localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(P_ADDR_DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    state_t                  state, state_nx;
    logic [AW:0]             issue_left, len_clamp;
    logic                    inflight, inflight_last, pop;
    logic [1:0]              buf_cnt, occ;
    logic [P_DATA_WIDTH-1:0] head_data, tail_data;
    logic                    head_last, tail_last;
    assign len_clamp = (i_len > LEN_MAX) ? LEN_MAX : i_len;
    assign o_valid   = buf_cnt != 2'd0;
    assign o_data    = head_data;
    assign o_last    = o_valid & head_last;
    assign pop       = o_valid & i_ready;
    // occupancy once this cycle's pop has left; the in-flight word lands on top of it
    assign occ       = buf_cnt - {1'b0, pop};
    assign o_busy    = state == S_READ;
    assign o_done    = state == S_DONE;
    // only issue when the word it returns is guaranteed a buffer slot
    assign o_ram_en  = (state == S_READ) && (issue_left != '0) &&
                       (({1'b0, occ} + {2'b0, inflight}) < 3'd2);
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = !i_start ? S_IDLE : (len_clamp == '0) ? S_DONE : S_READ;
            S_READ:  state_nx = (issue_left == '0 && !inflight && occ == 2'd0) ? S_DONE : S_READ;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ram_addr    <= '0;
            issue_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (state == S_IDLE && i_start) begin
                o_ram_addr <= i_base_addr;
                issue_left <= len_clamp;
            end else if (o_ram_en) begin
                // explicit compare so non-power-of-2 depths wrap too
                o_ram_addr <= (o_ram_addr == ADDR_LAST) ? '0 : o_ram_addr + ADDR_ONE;
                issue_left <= issue_left - LEN_ONE;
            end
            inflight      <= o_ram_en;
            inflight_last <= o_ram_en && issue_left == LEN_ONE;
        end
    end
    // 2-entry FIFO: head drives the stream, tail holds the second word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_cnt   <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            buf_cnt <= occ + {1'b0, inflight};
            if (pop && buf_cnt == 2'd2) begin
                head_data <= tail_data;
                head_last <= tail_last;
            end else if (inflight && occ == 2'd0) begin
                head_data <= i_ram_rdata;
                head_last <= inflight_last;
            end
            if (inflight && occ == 2'd1) begin
                tail_data <= i_ram_rdata;
                tail_last <= inflight_last;
            end
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench for ram_stream_reader against a RAM holding RAM[i] = i[3:0].
module tb_ram_stream_reader;
    localparam int DW = 4;
    localparam int DEPTH = 128;
    localparam int AW = 7;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, ram_en, valid, last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] rdata, data;
    int            n_cmp = 0;
    int            n_err = 0;
    int            beat_cnt = 0;
    int            en_cnt = 0;
    logic [AW-1:0] addr_q[$];
    logic [DW:0]   beat_q[$];
    logic          stalled = 1'b0;
    logic [DW:0]   stall_word, exp_beat;
    logic [AW-1:0] exp_addr;

    always #5 clk = ~clk;

    ram_stream_reader #(.P_DATA_WIDTH(DW), .P_ADDR_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base), .i_len(len),
        .o_busy(busy), .o_done(done), .o_ram_en(ram_en), .o_ram_addr(ram_addr),
        .i_ram_rdata(rdata), .o_valid(valid), .o_data(data), .o_last(last), .i_ready(ready)
    );

    always @(posedge clk) if (ram_en) rdata <= ram_addr[DW-1:0];

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            n_cmp++;
            if (dut.buf_cnt > 2'd2) begin
                n_err++;
                $display("FAIL buf_cnt: got %0d, limit 2", dut.buf_cnt);
            end
            if (stalled) begin
                n_cmp++;
                if ({valid, last, data} !== {1'b1, stall_word}) begin
                    n_err++;
                    $display("FAIL stall_hold: got valid=%0b last=%0b data=%0d, expected valid=1 last=%0b data=%0d",
                             valid, last, data, stall_word[DW], stall_word[DW-1:0]);
                end
            end
            if (ram_en) begin
                en_cnt++;
                n_cmp++;
                if (addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ram_addr: unexpected read of %0d", ram_addr);
                end else begin
                    exp_addr = addr_q.pop_front();
                    if (ram_addr !== exp_addr) begin
                        n_err++;
                        $display("FAIL ram_addr: got %0d, expected %0d", ram_addr, exp_addr);
                    end
                end
            end
            if (valid && ready) begin
                beat_cnt++;
                n_cmp++;
                if (beat_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat: unexpected beat data=%0d last=%0b", data, last);
                end else begin
                    exp_beat = beat_q.pop_front();
                    if ({last, data} !== exp_beat) begin
                        n_err++;
                        $display("FAIL beat: got data=%0d last=%0b, expected data=%0d last=%0b",
                                 data, last, exp_beat[DW-1:0], exp_beat[DW]);
                    end
                end
            end
            stalled = valid && !ready;
            stall_word = {last, data};
        end
    end

    task automatic start_job(input logic [AW-1:0] b, input logic [AW:0] l);
        int n;
        logic [AW-1:0] a;
        n = (int'(l) > DEPTH) ? DEPTH : int'(l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base = b;
        len = l;
        beat_cnt = 0;
        en_cnt = 0;
        for (int k = 0; k < n; k++) begin
            a = AW'((int'(b) + k) % DEPTH);
            addr_q.push_back(a);
            beat_q.push_back({(k == n - 1), a[DW-1:0]});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = -1;
        for (int c = 1; c <= max && cyc < 0; c++) begin
            @(negedge clk);
            if (done) cyc = c;
        end
    endtask

    task automatic test_reset;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, ram_en, ram_addr, valid, data, last} !== 16'd0) begin
                n_err++;
                $display("FAIL reset_outputs: got %h, expected 0",
                         {busy, done, ram_en, ram_addr, valid, data, last});
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, valid} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy/done/valid=%b, expected 000", {busy, done, valid});
        end
    endtask

    task automatic test_basic;
        int first_v = -1;
        int done_c = -1;
        int ndone = 0;
        logic busy1 = 1'b0;
        logic en1 = 1'b0;
        logic [AW-1:0] addr1 = '0;
        logic busy_d = 1'b1;
        start_job(7'd5, 8'd4);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                busy1 = busy;
                en1 = ram_en;
                addr1 = ram_addr;
            end
            if (valid && first_v < 0) first_v = c;
            if (done) begin
                ndone++;
                done_c = c;
                busy_d = busy;
            end
        end
        n_cmp++;
        if ({busy1, en1, addr1} !== {1'b1, 1'b1, 7'd5}) begin
            n_err++;
            $display("FAIL first_issue: got busy=%0b en=%0b addr=%0d, expected 1 1 5", busy1, en1, addr1);
        end
        n_cmp++;
        if (first_v !== 3) begin
            n_err++;
            $display("FAIL valid_latency: got cycle %0d, expected 3", first_v);
        end
        n_cmp++;
        if (done_c !== 7 || ndone !== 1) begin
            n_err++;
            $display("FAIL done_timing: got cycle %0d count %0d, expected cycle 7 count 1", done_c, ndone);
        end
        n_cmp++;
        if (busy_d !== 1'b0) begin
            n_err++;
            $display("FAIL busy_at_done: got %0b, expected 0", busy_d);
        end
        n_cmp++;
        if (beat_cnt !== 4 || beat_q.size() !== 0) begin
            n_err++;
            $display("FAIL basic_beats: got %0d beats, %0d left, expected 4 and 0", beat_cnt, beat_q.size());
        end
    endtask

    task automatic test_wrap;
        int cyc;
        start_job(7'd126, 8'd4);
        wait_done(30, cyc);
        n_cmp++;
        if (cyc !== 7) begin
            n_err++;
            $display("FAIL wrap_done: got cycle %0d, expected 7", cyc);
        end
        n_cmp++;
        if (beat_cnt !== 4 || addr_q.size() !== 0) begin
            n_err++;
            $display("FAIL wrap_beats: got %0d beats, %0d addrs left, expected 4 and 0", beat_cnt, addr_q.size());
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] pat = 4'b1001;
        int cyc = -1;
        start_job(7'd20, 8'd6);
        for (int c = 1; c <= 60 && cyc < 0; c++) begin
            ready = pat[3 - ((c - 1) % 4)];
            @(negedge clk);
            if (done) cyc = c;
            @(posedge clk);
            #1;
        end
        ready = 1'b1;
        n_cmp++;
        if (cyc < 0) begin
            n_err++;
            $display("FAIL bp_done: got timeout, expected o_done");
        end
        n_cmp++;
        if (en_cnt !== 6) begin
            n_err++;
            $display("FAIL bp_en_count: got %0d, expected 6", en_cnt);
        end
        n_cmp++;
        if (beat_cnt !== 6 || beat_q.size() !== 0) begin
            n_err++;
            $display("FAIL bp_beats: got %0d beats, %0d left, expected 6 and 0", beat_cnt, beat_q.size());
        end
    endtask

    task automatic test_empty;
        int done_c = -1;
        int ndone = 0;
        int nvalid = 0;
        int nbusy = 0;
        start_job(7'd9, 8'd0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                done_c = c;
            end
            if (valid) nvalid++;
            if (busy) nbusy++;
        end
        n_cmp++;
        if (done_c !== 1 || ndone !== 1) begin
            n_err++;
            $display("FAIL empty_done: got cycle %0d count %0d, expected cycle 1 count 1", done_c, ndone);
        end
        n_cmp++;
        if (en_cnt !== 0 || nvalid !== 0 || nbusy !== 0) begin
            n_err++;
            $display("FAIL empty_activity: got en=%0d valid=%0d busy=%0d, expected 0 0 0", en_cnt, nvalid, nbusy);
        end
    endtask

    task automatic test_clamp;
        int cyc;
        start_job(7'd10, 8'd200);
        for (int c = 0; c < 20; c++) @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        base = 7'd0;
        len = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(400, cyc);
        n_cmp++;
        if (cyc < 0) begin
            n_err++;
            $display("FAIL clamp_done: got timeout, expected o_done");
        end
        n_cmp++;
        if (beat_cnt !== 128 || en_cnt !== 128) begin
            n_err++;
            $display("FAIL clamp_count: got beats=%0d en=%0d, expected 128 128", beat_cnt, en_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, valid, ram_en} !== 3'b000 || beat_q.size() !== 0) begin
            n_err++;
            $display("FAIL clamp_idle: got busy/valid/en=%b left=%0d, expected 000 and 0",
                     {busy, valid, ram_en}, beat_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int ndone = 0;
        start_job(7'd40, 8'd8);
        for (int c = 0; c < 20 && beat_cnt < 2; c++) begin
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (beat_cnt !== 2) begin
            n_err++;
            $display("FAIL mid_beats: got %0d, expected 2", beat_cnt);
        end
        #1;
        rst = 1'b1;
        addr_q.delete();
        beat_q.delete();
        #1;
        n_cmp++;
        if ({busy, done, ram_en, ram_addr, valid, data, last} !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: got %h, expected 0", {busy, done, ram_en, ram_addr, valid, data, last});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d done/busy cycles, expected 0", ndone);
        end
        start_job(7'd3, 8'd3);
        wait_done(20, cyc);
        n_cmp++;
        if (cyc !== 6 || beat_cnt !== 3) begin
            n_err++;
            $display("FAIL post_reset_job: got done cycle %0d beats %0d, expected 6 and 3", cyc, beat_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_empty();
        test_clamp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish within 100000 ns, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
